// File: rtl/sram_cache_tiled_if.sv
// Request/response bus of the tiled cache SRAM wrapper.
//   master : requester side (drives req/we/addr/wuser/wdata/be, receives gnt/rvalid/ruser/rdata)
//   slave  : sram_cache_tiled side
interface sram_cache_tiled_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                      req_i;
    logic                      gnt_o;
    logic                      we_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic [USER_WIDTH-1:0]     wuser_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [DATA_WIDTH/8-1:0]   be_i;
    logic                      rvalid_o;
    logic [USER_WIDTH-1:0]     ruser_o;
    logic [DATA_WIDTH-1:0]     rdata_o;

    modport master (
        output req_i, we_i, addr_i, wuser_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, ruser_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wuser_i, wdata_i, be_i,
        output gnt_o, rvalid_o, ruser_o, rdata_o
    );
endinterface

// File: rtl/sram_cache_tiled.sv
// Tiled cache SRAM wrapper: builds a NUM_WORDS x (DATA_WIDTH[+USER_WIDTH]) array out of
// MACRO_DEPTH x MACRO_WIDTH single-port, 1-cycle-read macros and emulates byte enables with an
// internal read-modify-write sequence.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : req/gnt request channel plus rvalid/rdata/ruser response (sram_cache_tiled_if.slave)
module sram_cache_tiled #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned USER_EN     = 0,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter int unsigned MACRO_DEPTH = 256,
    parameter int unsigned MACRO_WIDTH = 256,
    parameter int unsigned OUT_REGS    = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sram_cache_tiled_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int unsigned MACRO_AW   = $clog2(MACRO_DEPTH);
    localparam int unsigned ROWS       = NUM_WORDS / MACRO_DEPTH;
    localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned WORD_W     = DATA_WIDTH + ((USER_EN != 0) ? USER_WIDTH : 0);
    localparam int unsigned COLS       = (WORD_W + MACRO_WIDTH - 1) / MACRO_WIDTH;
    localparam int unsigned PAD_W      = COLS * MACRO_WIDTH;
    localparam int unsigned BE_W       = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RMW_RD = 2'd1;
    localparam logic [1:0] RMW_WR = 2'd2;

    // Elaboration-time geometry checks
    if ((NUM_WORDS % MACRO_DEPTH) != 0) begin : g_bad_depth
        $error("NUM_WORDS must be a multiple of MACRO_DEPTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BE_W-1:0]        be_q;
    logic [USER_WIDTH-1:0]  wuser_q;
    logic                   rvalid_q;

    logic                   mem_ce_c;
    logic                   mem_we_c;
    logic [ADDR_WIDTH-1:0]  mem_addr_c;
    logic [PAD_W-1:0]       mem_wdata_c;
    logic [ROW_W-1:0]       mem_row_c;
    logic                   rd_issue_c;
    logic                   latch_c;

    logic [PAD_W-1:0]       rd_row [ROWS];
    logic [ROW_W-1:0]       row_q_c;
    logic [PAD_W-1:0]       rsel_c;
    logic [DATA_WIDTH-1:0]  merged_data_c;
    logic [PAD_W-1:0]       wword_c;
    logic [PAD_W-1:0]       merged_c;
    logic [USER_WIDTH-1:0]  ruser_c;

    assign bus.gnt_o = (state_q == IDLE);

    // Row of the latched address selects both the read-out mux and the RMW old data
    assign row_q_c   = ROW_W'(addr_q >> MACRO_AW);
    assign rsel_c    = rd_row[row_q_c];
    assign mem_row_c = ROW_W'(mem_addr_c >> MACRO_AW);

    // Byte merge of latched write data over the word read back during RMW_RD
    always_comb begin
        merged_data_c = rsel_c[DATA_WIDTH-1:0];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (be_q[b]) begin
                merged_data_c[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Word packing: user bits sit directly above the data, padding above that is zero
    if (USER_EN != 0) begin : g_user
        assign wword_c  = PAD_W'({bus.wuser_i, bus.wdata_i});
        assign merged_c = PAD_W'({wuser_q, merged_data_c});
        assign ruser_c  = rsel_c[DATA_WIDTH +: USER_WIDTH];
    end else begin : g_no_user
        logic unused_user;
        assign wword_c     = PAD_W'(bus.wdata_i);
        assign merged_c    = PAD_W'(merged_data_c);
        assign ruser_c     = '0;
        assign unused_user = ^{bus.wuser_i, wuser_q};
    end

    if (PAD_W > WORD_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^rsel_c[PAD_W-1:WORD_W];
    end

    // Next-state and macro control
    always_comb begin
        state_d     = state_q;
        mem_ce_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.addr_i;
        mem_wdata_c = wword_c;
        rd_issue_c  = 1'b0;
        latch_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (!bus.we_i) begin
                        mem_ce_c   = 1'b1;
                        rd_issue_c = 1'b1;
                    end else if (bus.be_i == {BE_W{1'b1}}) begin
                        mem_ce_c = 1'b1;
                        mem_we_c = 1'b1;
                    end else if (bus.be_i != '0) begin
                        mem_ce_c = 1'b1;
                        latch_c  = 1'b1;
                        state_d  = RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                mem_ce_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = addr_q;
                mem_wdata_c = merged_c;
                state_d     = RMW_WR;
            end
            RMW_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch and read-valid strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wuser_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rd_issue_c;
            if (rd_issue_c || latch_c) begin
                addr_q <= bus.addr_i;
            end
            if (latch_c) begin
                wdata_q <= bus.wdata_i;
                be_q    <= bus.be_i;
                wuser_q <= bus.wuser_i;
            end
        end
    end

    // Macro tiles: only the addressed row is enabled; all columns of a row share the address
    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        logic row_ce;
        assign row_ce = mem_ce_c && (mem_row_c == ROW_W'(r));
        for (genvar c = 0; c < int'(COLS); c++) begin : g_col
            logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];
            logic [MACRO_WIDTH-1:0] q;
            always_ff @(posedge clk_i) begin
                if (row_ce) begin
                    if (mem_we_c) begin
                        mem[mem_addr_c[MACRO_AW-1:0]] <= mem_wdata_c[c*MACRO_WIDTH +: MACRO_WIDTH];
                    end else begin
                        q <= mem[mem_addr_c[MACRO_AW-1:0]];
                    end
                end
            end
            assign rd_row[r][c*MACRO_WIDTH +: MACRO_WIDTH] = q;
        end
    end

    // Response path; data is forced to zero whenever rvalid is low
    if (OUT_REGS != 0) begin : g_out_reg
        logic                  rvalid_r;
        logic [DATA_WIDTH-1:0] rdata_r;
        logic [USER_WIDTH-1:0] ruser_r;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_r <= 1'b0;
                rdata_r  <= '0;
                ruser_r  <= '0;
            end else begin
                rvalid_r <= rvalid_q;
                rdata_r  <= rvalid_q ? rsel_c[DATA_WIDTH-1:0] : '0;
                ruser_r  <= rvalid_q ? ruser_c : '0;
            end
        end
        assign bus.rvalid_o = rvalid_r;
        assign bus.rdata_o  = rdata_r;
        assign bus.ruser_o  = ruser_r;
    end else begin : g_out_direct
        assign bus.rvalid_o = rvalid_q;
        assign bus.rdata_o  = rvalid_q ? rsel_c[DATA_WIDTH-1:0] : '0;
        assign bus.ruser_o  = rvalid_q ? ruser_c : '0;
    end
endmodule
